// File: rtl/alu_master_pkg.sv
// Shared processor package: FSM state encoding, default ALU master sizing and
// the polarity constants of the ALU ready/cs handshake.
package alu_master_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_TIMEOUT = 64;
  localparam int TIMER_W         = 16;   // wide enough for any TIMEOUT up to 65535

  // ALU handshake levels
  localparam logic READY_IDLE = 1'b1;    // responder idle / result valid
  localparam logic READY_BUSY = 1'b0;    // responder working
  localparam logic CS_ACTIVE  = 1'b1;
  localparam logic CS_IDLE    = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_CAPTURE   = 3'd4
  } state_t;

  // States in which the handshake timeout is running
  function automatic logic in_wait(input state_t s);
    return (s == ST_WAIT_ACK) || (s == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/alu_master_hs_timer.sv
// Handshake timeout counter: cleared on entry to a wait phase, counts while
// enabled; expired is high on the TIMEOUT-th cycle spent in the phase.
module hs_timer
  import alu_master_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: clear has priority so a phase change restarts the budget
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/alu_master.sv
// ALU master: takes an operand pair from upstream, runs the cs/ready
// handshake with an ALU responder and returns the captured result, with a
// timeout on each wait phase. Every output is a flop so bus/ready never
// reach an output combinationally.
module alu_master
  import alu_master_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             cs,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] bus,
  input  logic             ready
);

  state_t             state_q, state_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               tmr_clear, tmr_en, tmr_expired;

  hs_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // Next-state and next-output logic; done/err/cs/busy are decided here and
  // registered, so they appear on the cycle the FSM lands in its new state
  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmr_clear = 1'b0;
    tmr_en    = in_wait(state_q);
    unique case (state_q)
      ST_IDLE: begin
        // A start seen while the responder is still busy is simply dropped
        if (start && (ready == READY_IDLE)) begin
          a_d     = op_a;
          b_d     = op_b;
          cs_d    = CS_ACTIVE;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_clear = 1'b1;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // An acknowledge on the timeout cycle still counts as an acknowledge
        if (ready == READY_BUSY) begin
          cs_d      = CS_IDLE;
          tmr_clear = 1'b1;
          state_d   = ST_WAIT_DONE;
        end else if (tmr_expired) begin
          cs_d    = CS_IDLE;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (ready == READY_IDLE) begin
          state_d = ST_CAPTURE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        result_d = bus;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        cs_d    = CS_IDLE;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any transfer without a pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cs_q     <= CS_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign cs     = cs_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign a      = a_q;
  assign b      = b_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_master.sv
// Bench for alu_master: an adder responder with selectable behaviour, a
// transaction-level reference checked every cycle, and directed scenarios
// with hand-computed expectations.
module tb_alu_master;

  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [W-1:0] bus = '0;
  logic         ready = 1'b1;
  logic         busy, done, err, cs;
  logic [W-1:0] result, a, b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;   // 0 normal responder, 1 ready stuck high, 2 ready stuck low after ack
  int lat_n = 3;   // cycles ready stays low in normal mode

  alu_master #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .err(err), .result(result),
    .cs(cs), .a(a), .b(b), .bus(bus), .ready(ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ALU responder: looks at cs after each edge and updates ready/bus just after
  // the following edge, like a registered slave. The result is a + b.
  initial begin : responder
    logic         nr;
    logic [W-1:0] nb;
    int           rcnt;
    rcnt = 0;
    forever begin
      @(negedge clk);
      nr = ready;
      nb = bus;
      if (rst) begin
        nr = 1'b1; nb = '0; rcnt = 0;
      end else begin
        case (mode)
          0: begin
            if (ready && cs) begin
              nr = 1'b0; nb = 16'hDEAD; rcnt = lat_n;
            end else if (!ready) begin
              if (rcnt <= 1) begin nr = 1'b1; nb = a + b; rcnt = 0; end
              else rcnt--;
            end
          end
          1: nr = 1'b1;
          default: if (ready && cs) begin nr = 1'b0; nb = 16'hDEAD; end
        endcase
      end
      @(posedge clk);
      #1;
      ready = nr;
      bus   = nb;
    end
  end

  // Reference model: one transaction at a time, described by what has been
  // observed so far (age since accept, ack seen, completion seen, cycles waited).
  // Checked mid-cycle against what the DUT shows after the last edge, then
  // advanced with the inputs the DUT will sample at the next edge.
  logic         m_active = 0, m_acked = 0, m_seen = 0;
  logic         m_cs = 0, m_done = 0, m_err = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  int           m_age = 0, m_wait = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_active = 0; m_acked = 0; m_seen = 0; m_cs = 0; m_done = 0; m_err = 0;
      m_a = '0; m_b = '0; m_res = '0; m_age = 0; m_wait = 0;
    end
    chk("busy",   busy,   m_active);
    chk("cs",     cs,     m_cs);
    chk("done",   done,   m_done);
    chk("err",    err,    m_err);
    chk("a",      a,      m_a);
    chk("b",      b,      m_b);
    chk("result", result, m_res);
    if (!rst) begin
      m_done = 0;
      m_err  = 0;
      if (!m_active) begin
        if (start && ready) begin
          m_active = 1; m_a = op_a; m_b = op_b; m_cs = 1;
          m_age = 0; m_acked = 0; m_seen = 0; m_wait = 0;
        end
      end else begin
        m_age++;
        if (m_seen) begin
          m_res = bus; m_done = 1; m_active = 0;
        end else if (m_age == 1) begin
          m_wait = 0;
        end else if (!m_acked && !ready) begin
          m_acked = 1; m_cs = 0; m_wait = 0;
        end else if (m_acked && ready) begin
          m_seen = 1;
        end else begin
          m_wait++;
          if (m_wait >= TO) begin m_err = 1; m_cs = 0; m_active = 0; end
        end
      end
    end
  end

  task automatic run_until(input bit want_err, input int limit, output bit hit,
                           output int at, output int n_cs, output int n_done);
    hit = 0; at = 0; n_cs = 0; n_done = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      tick();
      if (cs) n_cs++;
      if (done) n_done++;
      if (want_err ? err : done) begin hit = 1; at = cyc; end
    end
  endtask

  initial begin : stim
    int p, q, ncs, nd, issues;
    bit hit, prev_cs;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_cs", cs, 0);
    chk("rst_result", result, 0);
    chk("rst_a", a, 0);

    // Normal op, start on the first edge after reset release: 3 + 4, N = 3
    mode = 0; lat_n = 3;
    rst = 0; start = 1; op_a = 16'h0003; op_b = 16'h0004; p = cyc;
    tick();
    start = 0;
    chk("first_accept_busy", busy, 1);
    chk("first_accept_cs", cs, 1);
    run_until(0, 40, hit, q, ncs, nd);
    chk("norm_done_seen", hit, 1);
    chk("norm_latency", q - p, 7);
    chk("norm_result", result, 16'h0007);
    chk("norm_cs_cycles", ncs + 1, 2);
    chk("norm_busy_at_done", busy, 0);

    // Stuck-ready responder: err 8 cycles after entering the ack wait
    mode = 1;
    start = 1; op_a = 16'h0009; op_b = 16'h0009; p = cyc;
    tick();
    start = 0;
    run_until(1, 40, hit, q, ncs, nd);
    chk("sr_err_seen", hit, 1);
    chk("sr_err_cycle", q - p, 10);
    chk("sr_result_kept", result, 16'h0007);
    chk("sr_cs_low", cs, 0);
    chk("sr_no_done", nd, 0);

    // Stuck-busy responder: err, then start ignored until ready returns
    mode = 2;
    start = 1; op_a = 16'h0002; op_b = 16'h0003; p = cyc;
    tick();
    start = 0;
    run_until(1, 40, hit, q, ncs, nd);
    chk("sb_err_seen", hit, 1);
    chk("sb_err_cycle", q - p, 11);
    chk("sb_idle", busy, 0);
    start = 1; op_a = 16'h0005; op_b = 16'h0006;
    repeat (3) begin
      tick();
      chk("sb_start_ignored", busy, 0);
    end
    mode = 0; lat_n = 3;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (busy) hit = 1;
    end
    chk("sb_accept_after_ready", hit, 1);
    start = 0;
    run_until(0, 40, hit, q, ncs, nd);
    chk("sb_next_done", hit, 1);
    chk("sb_next_result", result, 16'h000B);

    // Reset while waiting for the result
    lat_n = 20;
    start = 1; op_a = 16'h0010; op_b = 16'h0020;
    tick();
    start = 0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (busy && !cs) hit = 1;
    end
    chk("rwd_in_wait_done", hit, 1);
    rst = 1;
    #1;
    chk("rwd_cs", cs, 0);
    chk("rwd_busy", busy, 0);
    chk("rwd_result", result, 0);
    chk("rwd_done", done, 0);
    chk("rwd_err", err, 0);
    repeat (2) tick();
    lat_n = 3;
    rst = 0; start = 1; op_a = 16'h1234; op_b = 16'h0001;
    tick();
    start = 0;
    run_until(0, 40, hit, q, ncs, nd);
    chk("rwd_next_done", hit, 1);
    chk("rwd_next_result", result, 16'h1235);

    // Start held high, two back-to-back ops, operands changed while busy
    lat_n = 2;
    start = 1; op_a = 16'hFFFF; op_b = 16'h0001;
    issues = 0; prev_cs = 0; nd = 0; q = -10;
    for (int i = 0; i < 60 && nd < 2; i++) begin
      tick();
      if (i == 0) begin op_a = 16'h5555; op_b = 16'hAAAA; end
      if (cs && !prev_cs) issues++;
      prev_cs = cs;
      if (done) begin
        nd++;
        if (nd == 1) begin
          chk("b2b_result1", result, 16'h0000);
          chk("b2b_a_stable", a, 16'hFFFF);
          op_a = 16'h0001; op_b = 16'h0002; q = cyc;
        end else begin
          chk("b2b_result2", result, 16'h0003);
        end
      end
      if (nd == 1 && cyc == q + 1) begin
        chk("b2b_second_accept", busy, 1);
        start = 0;
      end
    end
    chk("b2b_done_count", nd, 2);
    chk("b2b_issue_count", issues, 2);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_master.md
ALU_MASTER -- requirements
Module: alu_master

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width.
REQ-002 Parameter TIMEOUT, default 64, max cycles waited in any handshake phase (range 2..65535).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  upstream request; sampled only in IDLE.
REQ-006 op_a, op_b  input  WIDTH  upstream operands; sampled with start.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse when result is valid.
REQ-009 err  output  1  one-cycle pulse on handshake timeout.
REQ-010 result  output  WIDTH  last captured ALU result; held until next capture.
REQ-011 cs  output  1  chip select to ALU responder.
REQ-012 a, b  output  WIDTH  operands to ALU; stable from ISSUE until return to IDLE.
REQ-013 bus  input  WIDTH  ALU result bus.
REQ-014 ready  input  1  ALU status: high = idle/result valid, low = operation in progress.

Function
REQ-015 States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, CAPTURE.
REQ-016 IDLE: start=1 and ready=1 -> latch op_a/op_b into a/b, go ISSUE; start=1 with ready=0 is ignored (start stays pending only while held).
REQ-017 ISSUE: cs=1; go WAIT_ACK next cycle.
REQ-018 WAIT_ACK: cs held 1; ready=0 observed -> cs=0, go WAIT_DONE; otherwise stay.
REQ-019 WAIT_DONE: cs=0; ready=1 observed -> go CAPTURE; otherwise stay.
REQ-020 CAPTURE: result <= bus, done=1 for this cycle, go IDLE.
REQ-021 Timeout counter clears on entry to WAIT_ACK and WAIT_DONE, increments each cycle in those states; reaching TIMEOUT -> err=1 one cycle, cs=0, result unchanged, go IDLE.
REQ-022 Latency with responder that drops ready 1 cycle after cs and raises it N cycles later: start-to-done = N+4 cycles.
REQ-023 done and err never both high in the same cycle.
REQ-024 start while busy is ignored; no queuing.
REQ-025 cs is registered (glitch-free); only ISSUE and WAIT_ACK drive cs=1.
REQ-026 Back-to-back: start may be accepted on the cycle after CAPTURE.

Reset
REQ-027 Reset values: state IDLE, cs 0, a 0, b 0, result 0, busy 0, done 0, err 0, counter 0.
REQ-028 Reset asserted mid-operation aborts immediately: cs drops asynchronously, no done/err pulse generated.
REQ-029 First start honoured on first clock edge after rst deasserts.

Structure
REQ-030 State encoding and default WIDTH/TIMEOUT constants SHALL live in the shared processor package alongside ALU handshake constants.
REQ-031 Timeout counter SHALL be a sub-module hs_timer (clear, enable, expired output).
REQ-032 No combinational path from bus or ready to any output.

Verification
REQ-033 Normal op: op_a=16'h0003, op_b=16'h0004, responder returns 16'h0007 after ready low 3 cycles -> cs high 2..3 cycles, done pulse, result=16'h0007, busy falls same cycle done pulses ends.
REQ-034 Stuck-ready responder (ready never drops), TIMEOUT=8 -> err pulse 8 cycles after WAIT_ACK entry, cs=0, result unchanged, done never asserted.
REQ-035 Stuck-busy responder (ready stays 0 after ack), TIMEOUT=8 -> err pulse, return to IDLE, next start accepted once ready=1.
REQ-036 Reset in WAIT_DONE -> cs, busy, result cleared at once; no done/err; subsequent op 16'h1234+16'h0001 completes with result=16'h1235.
REQ-037 Start held high during operation and two back-to-back ops (16'hFFFF, 16'h0001) -> exactly one issue per accepted start, second accepted cycle after first done, results captured in order, a/b stable while busy.
